// File: rtl/instr_fetch_unit_pkg.sv
// Shared core definitions for the RV32I fetch stage: data width, NOP encoding,
// selected opcodes and the fetch sequencer state type.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: sequences word reads from instruction memory, latches the returned
// word into the IR and hands it to decode; execute redirects squash in-flight work.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_misalign
);

    import instr_fetch_unit_pkg::*;

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] target_aligned;

    assign target_aligned = {redirect_target[XLEN-1:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        discard_d  = discard_q;

        if (redirect_valid) begin
            fetch_pc_d = target_aligned;
            valid_d    = 1'b0;
            ir_d       = NOP_INSTR;
            misalign_d = (redirect_target[1:0] != 2'b00);
            state_d    = StReq;
            // An ack in this same cycle retires the old request; otherwise it is still owed.
            if (state_q == StReq) begin
                discard_d = !imem_ack;
            end
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (imem_ack) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            ir_d       = imem_rdata;
                            instr_pc_d = fetch_pc_q;
                            fetch_pc_d = fetch_pc_q + 32'd4;
                            valid_d    = 1'b1;
                            state_d    = StHold;
                        end
                    end
                end
                StHold: begin
                    if (valid_q && instr_ready) begin
                        valid_d = 1'b0;
                        state_d = StReq;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // The memory address only moves when a new request starts, never mid-request.
        if ((state_d == StReq) && ((state_q != StReq) || imem_ack)) begin
            addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC_ALIGNED;
            addr_q     <= RESET_PC_ALIGNED;
            ir_q       <= NOP_INSTR;
            instr_pc_q <= RESET_PC_ALIGNED;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            discard_q  <= discard_d;
        end
    end

    assign imem_req       = (state_q == StReq);
    assign imem_addr      = addr_q;
    assign instr_valid    = valid_q;
    assign instruction    = ir_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder pushes expected {pc, word} pairs when it acks,
// and decode-side observation pops and compares them.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fetch_misalign;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .fetch_misalign (fetch_misalign)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h5A00_0000 ^ {a[15:0], ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // One-cycle ack for the current address; keep=1 means the word must reach decode.
    task automatic ack_now(input bit keep);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        if (keep) exp_q.push_back('{pc: imem_addr, ins: mem_word(imem_addr)});
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
        total++; if (instruction !== NOP) begin bad++; $display("FAIL rst_ir got=%h want=%h", instruction, NOP); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", instr_pc); end
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b want=0", fetch_misalign); end
        rst_n = 1'b1;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL rst_first_req got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        bit   ok;
        exp_t e;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req(ok);
            total++; if (!ok) begin bad++; $display("FAIL seq_req%0d got=timeout want=req", k); end
            total++; if (imem_addr !== 32'(k * 4)) begin
                bad++; $display("FAIL seq_addr%0d got=%h want=%h", k, imem_addr, 32'(k * 4));
            end
            ack_now(1'b1);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_req_drop%0d got=%b want=0", k, imem_req); end
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%b want=1", k, instr_valid); end
            e = exp_q.pop_front();
            total++; if (instruction !== e.ins || instr_pc !== e.pc) begin
                bad++; $display("FAIL seq_data%0d got=%h@%h want=%h@%h", k, instruction, instr_pc, e.ins, e.pc);
            end
            tick();
        end
    endtask

    task automatic test_ack_delay();
        bit          ok;
        logic [31:0] a0;
        instr_ready = 1'b0;
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL dly_req got=timeout want=req"); end
        a0 = imem_addr;
        total++; if (a0 !== 32'hC) begin bad++; $display("FAIL dly_addr got=%h want=0000000c", a0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_req !== 1'b1 || imem_addr !== a0) begin
                bad++; $display("FAIL dly_stable%0d got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, a0);
            end
        end
        ack_now(1'b1);
        total++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            bad++; $display("FAIL dly_capture got valid=%b req=%b want valid=1 req=0", instr_valid, imem_req);
        end
        total++; if (instruction !== exp_q[0].ins || instr_pc !== exp_q[0].pc) begin
            bad++; $display("FAIL dly_data got=%h@%h want=%h@%h", instruction, instr_pc, exp_q[0].ins, exp_q[0].pc);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            // A stray ack while holding must be ignored.
            if (i == 2) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end
            tick();
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
            total++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instruction !== exp_q[0].ins) begin
                bad++; $display("FAIL hold%0d got valid=%b req=%b ir=%h want valid=1 req=0 ir=%h",
                                i, instr_valid, imem_req, instruction, exp_q[0].ins);
            end
        end
        instr_ready = 1'b1;
        e = exp_q.pop_front();
        total++; if (instruction !== e.ins || instr_pc !== e.pc) begin
            bad++; $display("FAIL hold_release got=%h@%h want=%h@%h", instruction, instr_pc, e.ins, e.pc);
        end
        tick();
    endtask

    task automatic test_redirect_discard();
        bit          ok;
        logic [31:0] a;
        exp_t        e;
        wait_req(ok);
        a = imem_addr;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        tick();
        redirect_valid  = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== a || fetch_misalign !== 1'b0) begin
            bad++; $display("FAIL redir_hold got req=%b addr=%h mis=%b want req=1 addr=%h mis=0",
                            imem_req, imem_addr, fetch_misalign, a);
        end
        tick();
        total++; if (imem_addr !== a) begin bad++; $display("FAIL redir_hold2 got=%h want=%h", imem_addr, a); end
        ack_now(1'b0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL redir_newreq got req=%b addr=%h valid=%b want req=1 addr=00000100 valid=0",
                            imem_req, imem_addr, instr_valid);
        end
        ack_now(1'b1);
        e = exp_q.pop_front();
        total++; if (instr_valid !== 1'b1 || instruction !== e.ins || instr_pc !== 32'h100) begin
            bad++; $display("FAIL redir_data got v=%b %h@%h want v=1 %h@00000100", instr_valid, instruction, instr_pc, e.ins);
        end
        tick();
    endtask

    task automatic test_misalign();
        bit   ok;
        exp_t e;
        wait_req(ok);
        instr_ready = 1'b0;
        ack_now(1'b0);
        // Redirect and ready in the same HOLD cycle: the redirect wins.
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0202;
        tick();
        redirect_valid  = 1'b0;
        total++; if (fetch_misalign !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b want=1", fetch_misalign); end
        total++; if (instr_valid !== 1'b0 || instruction !== NOP) begin
            bad++; $display("FAIL mis_flush got valid=%b ir=%h want valid=0 ir=%h", instr_valid, instruction, NOP);
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL mis_addr got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr);
        end
        tick();
        total++; if (fetch_misalign !== 1'b0) begin bad++; $display("FAIL mis_once got=%b want=0", fetch_misalign); end
        ack_now(1'b1);
        e = exp_q.pop_front();
        total++; if (instr_valid !== 1'b1 || instruction !== e.ins || instr_pc !== e.pc) begin
            bad++; $display("FAIL mis_data got v=%b %h@%h want v=1 %h@%h", instr_valid, instruction, instr_pc, e.ins, e.pc);
        end
        tick();
    endtask

    task automatic test_reset_ack();
        bit   ok;
        exp_t e;
        wait_req(ok);
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick();
        rst_n      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        total++; if (instruction !== NOP || instr_valid !== 1'b0 || imem_req !== 1'b0 || instr_pc !== 32'h0) begin
            bad++; $display("FAIL rstack_state got ir=%h v=%b req=%b pc=%h want ir=%h v=0 req=0 pc=0",
                            instruction, instr_valid, imem_req, instr_pc, NOP);
        end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL rstack_refetch got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
        ack_now(1'b1);
        e = exp_q.pop_front();
        total++; if (instruction !== e.ins || instr_pc !== e.pc) begin
            bad++; $display("FAIL rstack_data got=%h@%h want=%h@%h", instruction, instr_pc, e.ins, e.pc);
        end
        tick();
    endtask

    task automatic test_wrap_and_redirect_ack();
        bit   ok;
        exp_t e;
        wait_req(ok);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid  = 1'b0;
        ack_now(1'b0);
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h want=fffffffc", imem_addr); end
        ack_now(1'b1);
        e = exp_q.pop_front();
        total++; if (instruction !== e.ins || instr_pc !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_data got=%h@%h want=%h@fffffffc", instruction, instr_pc, e.ins);
        end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_next got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
        // Redirect coinciding with the ack: data dropped, no pending discard left behind.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0300;
        ack_now(1'b0);
        redirect_valid  = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL redack_req got req=%b addr=%h v=%b want req=1 addr=00000300 v=0",
                            imem_req, imem_addr, instr_valid);
        end
        ack_now(1'b1);
        e = exp_q.pop_front();
        total++; if (instr_valid !== 1'b1 || instruction !== e.ins || instr_pc !== 32'h300) begin
            bad++; $display("FAIL redack_data got v=%b %h@%h want v=1 %h@00000300", instr_valid, instruction, instr_pc, e.ins);
        end
        tick();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_empty got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        test_reset();
        test_sequential();
        test_ack_delay();
        test_hold();
        test_redirect_discard();
        test_misalign();
        test_reset_ack();
        test_wrap_and_redirect_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
